// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared types and constants for the ysyx_22040365 instruction fetch unit.
// FSM state encoding, next-PC select, reset PC, NOP encoding and PC step.
package ysyx_22040365_ifu_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/ysyx_22040365_pc.sv
// PC register of the fetch unit with its next-PC mux (redirect / pc+4 / hold).
// The increment wraps silently at 2^XLEN.
module ysyx_22040365_pc
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // NOTE: pc_d gets a default before the case so no select value can infer a latch.
  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel_i)
      PC_INC:   pc_d = pc_q + XLEN'(PC_STEP);
      PC_REDIR: pc_d = redirect_pc_i;
      default:  ;
    endcase
  end

  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one outstanding imem request, one buffered instruction.
// Optional misaligned-redirect trap: define YSYX_22040365_IFU_MISALIGN_CHK_EN.
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
  ,
  output logic            if_exc
`endif
);

  ifu_state_e      state_q;
  logic            drop_q;
  logic [ILEN-1:0] if_inst_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redir_pc;
  pc_sel_e         pc_sel;
  ifu_state_e      fetch_st;

`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
  logic redir_mis;
  logic exc_q;
  assign redir_pc  = redirect_pc;
  assign redir_mis = redirect_valid && (state_q != ST_RST) && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc  = redirect_pc & ~XLEN'(3);
`endif

  // A stale response still in flight must drain before a new request goes out.
  assign fetch_st = (drop_q && !imem_rsp_valid) ? ST_WAIT : ST_REQ;

  always_comb begin
    pc_sel = PC_HOLD;
    unique case (state_q)
      ST_REQ, ST_WAIT: if (redirect_valid) pc_sel = PC_REDIR;
      ST_HOLD: begin
        if (redirect_valid) pc_sel = PC_REDIR;
        else if (if_ready)  pc_sel = PC_INC;
      end
      default: ;
    endcase
  end

  ysyx_22040365_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .pc_sel_i      (pc_sel),
    .redirect_pc_i (redir_pc),
    .pc_o          (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RST;
      drop_q    <= 1'b0;
      if_inst_q <= ILEN'(NOP_INST);
      if_pc_q   <= RESET_PC;
    end else begin
      unique case (state_q)
        ST_RST: state_q <= ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) begin
            drop_q  <= redirect_valid;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            drop_q  <= !imem_rsp_valid;
            state_q <= imem_rsp_valid ? ST_REQ : ST_WAIT;
          end else if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= ST_REQ;
            end else begin
              if_inst_q <= imem_rsp_data;
              if_pc_q   <= pc_q;
              state_q   <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (imem_rsp_valid) drop_q <= 1'b0;
          if (redirect_valid || if_ready) state_q <= fetch_st;
        end
      endcase
`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
      // Misaligned redirect overrides the normal transition: present a trapped NOP.
      if (redir_mis) begin
        state_q   <= ST_HOLD;
        if_inst_q <= ILEN'(NOP_INST);
        if_pc_q   <= redirect_pc;
      end
`endif
    end
  end

`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      exc_q <= 1'b0;
    else if (redir_mis)
      exc_q <= 1'b1;
    else if (state_q == ST_WAIT && imem_rsp_valid && !drop_q && !redirect_valid)
      exc_q <= 1'b0;
  end
  assign if_exc = exc_q;
`endif

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == ST_HOLD);
  assign if_inst        = if_inst_q;
  assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Scoreboard bench for ysyx_22040365_ifu: directed stimulus pushes expected
// requests and decode handshakes; a monitor pops and compares them.
module tb_ysyx_22040365_ifu;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } if_exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
  logic        if_exc;
`endif

  logic [63:0] exp_req[$];
  if_exp_t     exp_if[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          rsp_lat = 1;

  ysyx_22040365_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
    ,
    .if_exc         (if_exc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0010_0093;
      64'h8000_0004: return 32'h0020_0113;
      64'h8000_0008: return 32'h0030_0193;
      default:       return 32'h0000_0013 | {a[11:0], 20'h0};
    endcase
  endfunction

  // Memory model: answers each accepted request rsp_lat cycles later, even across a reset.
  initial begin : responder
    int          pend_cnt = 0;
    logic [63:0] pend_addr = '0;
    logic        fire;
    logic [63:0] fire_addr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire      = imem_req_valid && imem_req_ready && !rst;
      fire_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (fire) begin
        pend_addr = fire_addr;
        pend_cnt  = rsp_lat;
      end
      if (pend_cnt > 0) begin
        if (pend_cnt == 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = inst_of(pend_addr);
        end
        pend_cnt--;
      end
    end
  end

  initial begin : monitor
    if_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req_valid && imem_req_ready) begin
          check("req_expected", 64'(exp_req.size() != 0), 64'd1);
          if (exp_req.size() != 0) check("req_addr", imem_req_addr, exp_req.pop_front());
        end
        if (if_valid && if_ready) begin
          check("if_expected", 64'(exp_if.size() != 0), 64'd1);
          if (exp_if.size() != 0) begin
            e = exp_if.pop_front();
            check("if_pc", if_pc, e.pc);
            check("if_inst", 64'(if_inst), 64'(e.inst));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [63:0] pc, input logic [31:0] inst);
    if_exp_t e;
    e.pc   = pc;
    e.inst = inst;
    exp_if.push_back(e);
  endtask

  task automatic wait_req_drain();
    int n = 0;
    while (exp_req.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    imem_req_ready = 1'b0;
    check("req_drain_timeout", 64'(exp_req.size()), 64'd0);
    exp_req.delete();
  endtask

  task automatic wait_if_drain();
    int n = 0;
    while (exp_if.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("if_drain_timeout", 64'(exp_if.size()), 64'd0);
    exp_if.delete();
  endtask

  task automatic wait_if_valid();
    int n = 0;
    while (!if_valid && n < 100) begin
      tick();
      n++;
    end
    check("if_valid_timeout", 64'(if_valid), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    check({tag, "_if_valid"},  64'(if_valid),       64'd0);
    check({tag, "_if_inst"},   64'(if_inst),        64'h0000_0013);
    check({tag, "_if_pc"},     if_pc,               64'h8000_0000);
    check({tag, "_req_addr"},  imem_req_addr,       64'h8000_0000);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Reset release, first fetch, sustained fetch of three instructions.
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_req.push_back(64'h8000_0008);
    push_if(64'h8000_0000, 32'h0010_0093);
    push_if(64'h8000_0004, 32'h0020_0113);
    push_if(64'h8000_0008, 32'h0030_0193);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_req_addr",  imem_req_addr,       64'h8000_0000);
    wait_req_drain();
    wait_if_drain();

    // Decode stalls for 5 cycles in HOLD.
    if_ready = 1'b0;
    exp_req.push_back(64'h8000_000C);
    imem_req_ready = 1'b1;
    wait_req_drain();
    wait_if_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_if_valid",  64'(if_valid),       64'd1);
      check("stall_if_inst",   64'(if_inst),        64'h00C0_0013);
      check("stall_if_pc",     if_pc,               64'h8000_000C);
      check("stall_req_valid", 64'(imem_req_valid), 64'd0);
      tick();
    end
    push_if(64'h8000_000C, 32'h00C0_0013);
    if_ready = 1'b1;
    wait_if_drain();

    // Redirect during WAIT; the in-flight response lands two cycles later and is dropped.
    rsp_lat = 3;
    exp_req.push_back(64'h8000_0010);
    imem_req_ready = 1'b1;
    wait_req_drain();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    rsp_lat        = 1;
    exp_req.push_back(64'h8000_0100);
    push_if(64'h8000_0100, 32'h1000_0013);
    imem_req_ready = 1'b1;
    wait_req_drain();
    wait_if_drain();

    // Redirect with if_ready in HOLD, then redirect with req_ready in REQ.
    if_ready = 1'b0;
    exp_req.push_back(64'h8000_0104);
    imem_req_ready = 1'b1;
    wait_req_drain();
    wait_if_valid();
    push_if(64'h8000_0104, 32'h1040_0013);
    push_if(64'h8000_0300, 32'h3000_0013);
    exp_req.push_back(64'h8000_0200);
    exp_req.push_back(64'h8000_0300);
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    tick();
    check("hold_redirect_addr",  imem_req_addr,       64'h8000_0200);
    check("hold_redirect_valid", 64'(if_valid),       64'd0);
    redirect_pc    = 64'h8000_0300;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    wait_req_drain();
    wait_if_drain();

`ifdef YSYX_22040365_IFU_MISALIGN_CHK_EN
    // Misaligned redirect traps without fetching.
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    check("mis_if_valid",  64'(if_valid),       64'd1);
    check("mis_if_exc",    64'(if_exc),         64'd1);
    check("mis_if_inst",   64'(if_inst),        64'h0000_0013);
    check("mis_if_pc",     if_pc,               64'h8000_0102);
    check("mis_req_valid", 64'(imem_req_valid), 64'd0);
    push_if(64'h8000_0102, 32'h0000_0013);
    if_ready = 1'b1;
    wait_if_drain();
`else
    // Low address bits of a redirect are forced to zero.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    check("align_req_addr", imem_req_addr, 64'h8000_0100);
    exp_req.push_back(64'h8000_0100);
    push_if(64'h8000_0100, 32'h1000_0013);
    imem_req_ready = 1'b1;
    wait_req_drain();
    wait_if_drain();
`endif

    // Reset mid-WAIT; the late response to the aborted request is ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    rsp_lat        = 4;
    exp_req.push_back(64'h8000_0400);
    imem_req_ready = 1'b1;
    wait_req_drain();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midwait_reset");
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("stale_rsp_if_valid", 64'(if_valid), 64'd0);
    rsp_lat = 1;
    exp_req.push_back(64'h8000_0000);
    push_if(64'h8000_0000, 32'h0010_0093);
    imem_req_ready = 1'b1;
    wait_req_drain();
    wait_if_drain();

    repeat (5) tick();
    check("leftover_req", 64'(exp_req.size()), 64'd0);
    check("leftover_if",  64'(exp_if.size()),  64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
